mbc1_responder: RTL and testbench

MBC1_RESPONDER -- requirements
Module: mbc1_responder

---
 rtl/gb_cart_pkg.sv | 22 ++
 rtl/bus_sync_edge.sv | 31 +++
 rtl/mbc1_responder.sv | 167 ++++++++++++++++
 tb/tb_mbc1_responder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_cart_pkg.sv
// rtl/gb_cart_pkg.sv - shared FSM states, region bases and RAM enable key for the cartridge responder
package gb_cart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRIVE,
    ST_RAMWR,
    ST_WAIT_END
  } state_e;

  localparam logic [15:0] BANK1_BASE = 16'h2000;
  localparam logic [15:0] BANK2_BASE = 16'h4000;
  localparam logic [15:0] MODE_BASE  = 16'h6000;
  localparam logic [15:0] RAM_BASE   = 16'hA000;
  localparam logic [3:0]  RAM_EN_KEY = 4'hA;

  function automatic logic in_ram_window(input logic [15:0] a);
    return a[15:13] == RAM_BASE[15:13];
  endfunction

endpackage

// File: rtl/bus_sync_edge.sv
// rtl/bus_sync_edge.sv - synchronizes one active-low bus strobe and flags its falling edge
module bus_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_n_i,
  output logic sync_n_o,
  output logic fell_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q[0] <= async_n_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_n_o = sync_q[STAGES-1];
  assign fell_o   = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/mbc1_responder.sv
// rtl/mbc1_responder.sv - MBC1-style cartridge bank controller bridging console strobes to a ROM/RAM backing store
module mbc1_responder
  import gb_cart_pkg::*;
#(
  parameter int ROM_BANKS   = 128,
  parameter int RAM_BANKS   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bus_a,
  input  logic [7:0]  bus_d_in,
  output logic [7:0]  bus_d_out,
  output logic        bus_d_oe,
  input  logic        bus_rd_n,
  input  logic        bus_wr_n,
  input  logic        bus_cs_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel,
  output logic [20:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata
);

  localparam logic [6:0] ROM_MASK = 7'(ROM_BANKS - 1);
  localparam logic [1:0] RAM_MASK = 2'(RAM_BANKS - 1);

  logic rd_sync_n, rd_fell;
  logic wr_sync_n, wr_fell;
  logic cs_sync_n, cs_fell_unused;

  bus_sync_edge #(.STAGES(SYNC_STAGES)) u_rd_sync (
    .clk(clk), .rst(rst), .async_n_i(bus_rd_n), .sync_n_o(rd_sync_n), .fell_o(rd_fell)
  );
  bus_sync_edge #(.STAGES(SYNC_STAGES)) u_wr_sync (
    .clk(clk), .rst(rst), .async_n_i(bus_wr_n), .sync_n_o(wr_sync_n), .fell_o(wr_fell)
  );
  bus_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .rst(rst), .async_n_i(bus_cs_n), .sync_n_o(cs_sync_n), .fell_o(cs_fell_unused)
  );

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  dout_q, dout_d;
  logic        ram_en_q, ram_en_d;
  logic [4:0]  bank1_q, bank1_d;
  logic [1:0]  bank2_q, bank2_d;
  logic        mode_q, mode_d;
  logic        abort_q, abort_d;

  logic ram_hit;
  assign ram_hit = ~cs_sync_n & in_ram_window(bus_a);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      dout_q   <= 8'hFF;
      ram_en_q <= 1'b0;
      bank1_q  <= 5'd1;
      bank2_q  <= 2'd0;
      mode_q   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      dout_q   <= dout_d;
      ram_en_q <= ram_en_d;
      bank1_q  <= bank1_d;
      bank2_q  <= bank2_d;
      mode_q   <= mode_d;
      abort_q  <= abort_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    dout_d   = dout_q;
    ram_en_d = ram_en_q;
    bank1_d  = bank1_q;
    bank2_d  = bank2_q;
    mode_d   = mode_q;
    abort_d  = abort_q;
    unique case (state_q)
      ST_IDLE: begin
        // A write wins over a read that falls in the same cycle.
        if (wr_fell) begin
          addr_d  = bus_a;
          wdata_d = bus_d_in;
          state_d = ST_WAIT_END;
          if (!bus_a[15]) begin
            if (bus_a[14:13] == BANK1_BASE[14:13]) begin
              bank1_d = (bus_d_in[4:0] == 5'd0) ? 5'd1 : bus_d_in[4:0];
            end else if (bus_a[14:13] == BANK2_BASE[14:13]) begin
              bank2_d = bus_d_in[1:0];
            end else if (bus_a[14:13] == MODE_BASE[14:13]) begin
              mode_d = bus_d_in[0];
            end else begin
              ram_en_d = (bus_d_in[3:0] == RAM_EN_KEY);
            end
          end else if (ram_hit && ram_en_q) begin
            state_d = ST_RAMWR;
          end
        end else if (rd_fell) begin
          addr_d  = bus_a;
          abort_d = 1'b0;
          if (!bus_a[15] || (ram_hit && ram_en_q)) begin
            state_d = ST_FETCH;
          end else begin
            dout_d  = 8'hFF;
            state_d = ST_DRIVE;
          end
        end
      end
      ST_FETCH: begin
        if (rd_sync_n) abort_d = 1'b1;
        if (mem_ack) begin
          if (abort_q || rd_sync_n) begin
            state_d = ST_IDLE;
          end else begin
            dout_d  = mem_rdata;
            state_d = ST_DRIVE;
          end
        end
      end
      ST_DRIVE: begin
        if (rd_sync_n) state_d = ST_IDLE;
      end
      ST_RAMWR: begin
        if (mem_ack) state_d = ST_WAIT_END;
      end
      ST_WAIT_END: begin
        if (wr_sync_n) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic [6:0] rom_bank;
  logic [1:0] ram_bank;

  always_comb begin
    rom_bank = '0;
    if (addr_q[14]) begin
      rom_bank = {bank2_q, bank1_q} & ROM_MASK;
    end else if (mode_q) begin
      rom_bank = {bank2_q, 5'd0} & ROM_MASK;
    end
    ram_bank = (mode_q ? bank2_q : 2'd0) & RAM_MASK;
  end

  assign mem_req   = (state_q == ST_FETCH) || (state_q == ST_RAMWR);
  assign mem_we    = (state_q == ST_RAMWR);
  assign mem_sel   = addr_q[15];
  assign mem_addr  = addr_q[15] ? {6'd0, ram_bank, addr_q[12:0]} : {rom_bank, addr_q[13:0]};
  assign mem_wdata = wdata_q;
  assign bus_d_out = dout_q;
  assign bus_d_oe  = (state_q == ST_DRIVE);

endmodule

// File: tb/tb_mbc1_responder.sv
// tb/tb_mbc1_responder.sv - randomized self-checking bench for mbc1_responder against a bank-arithmetic model
module tb_mbc1_responder;

  localparam int SYNC = 2;
  localparam int ROMB = 128;
  localparam int RAMB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bus_a = '0;
  logic [7:0]  bus_d_in = '0;
  logic [7:0]  bus_d_out;
  logic        bus_d_oe;
  logic        bus_rd_n = 1'b1;
  logic        bus_wr_n = 1'b1;
  logic        bus_cs_n = 1'b1;
  logic        mem_req, mem_we, mem_sel;
  logic [20:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;

  mbc1_responder #(.ROM_BANKS(ROMB), .RAM_BANKS(RAMB), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .bus_a(bus_a), .bus_d_in(bus_d_in),
    .bus_d_out(bus_d_out), .bus_d_oe(bus_d_oe),
    .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n), .bus_cs_n(bus_cs_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural cartridge register model
  int unsigned m_ram_en, m_bank1, m_bank2, m_mode;

  task automatic model_reset();
    m_ram_en = 0; m_bank1 = 1; m_bank2 = 0; m_mode = 0;
  endtask

  task automatic model_write(input int unsigned a, input int unsigned d);
    if (a < 32768) begin
      case (a / 8192)
        0: m_ram_en = ((d % 16) == 10) ? 1 : 0;
        1: m_bank1  = ((d % 32) == 0) ? 1 : (d % 32);
        2: m_bank2  = d % 4;
        default: m_mode = d % 2;
      endcase
    end
  endtask

  function automatic int unsigned exp_addr(input int unsigned a);
    int unsigned bank;
    if (a < 32768) begin
      if (a >= 16384) bank = m_bank2 * 32 + m_bank1;
      else            bank = (m_mode != 0) ? m_bank2 * 32 : 0;
      return (bank % ROMB) * 16384 + (a % 16384);
    end
    bank = (m_mode != 0) ? m_bank2 : 0;
    return (bank % RAMB) * 8192 + (a % 8192);
  endfunction

  function automatic bit ram_window(input int unsigned a, input logic cs_n);
    return !cs_n && a >= 32'hA000 && a < 32'hC000;
  endfunction

  // Backing-store responder: captures each request and acks after a delay
  int unsigned req_cnt = 0;
  int unsigned ack_cnt = 0;
  logic [20:0] req_addr = '0;
  logic        req_sel = 1'b0, req_we = 1'b0;
  logic [7:0]  req_wdata = '0;
  logic [7:0]  rd_next = '0;
  bit          busy = 0, hold_ack = 0, late_ack = 0;
  int          delay = 0;
  int          force_delay = -1;

  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (late_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = 8'h99;
      late_ack  = 0;
    end else if (mem_req && !rst) begin
      if (!busy) begin
        busy      = 1;
        delay     = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
        req_cnt++;
        req_addr  = mem_addr;
        req_sel   = mem_sel;
        req_we    = mem_we;
        req_wdata = mem_wdata;
      end
      if (!hold_ack) begin
        if (delay == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = rd_next;
          ack_cnt++;
          busy = 0;
        end else begin
          delay--;
        end
      end
    end else begin
      busy = 0;
    end
  end

  int last_lat;

  task automatic do_read(input logic [15:0] a, input logic cs_n);
    int unsigned cnt0, ea;
    bit mapped;
    cnt0    = req_cnt;
    ea      = exp_addr(a);
    mapped  = (a < 16'h8000) || (ram_window(a, cs_n) && m_ram_en != 0);
    rd_next = 8'($urandom);
    @(negedge clk);
    bus_a    = a;
    bus_cs_n = cs_n;
    bus_rd_n = 1'b0;
    last_lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      last_lat++;
      if (bus_d_oe) break;
    end
    check_eq("rd_oe", bus_d_oe, 1);
    if (mapped) begin
      check_eq("rd_req_cnt", req_cnt, cnt0 + 1);
      check_eq("rd_addr", req_addr, ea);
      check_eq("rd_sel", req_sel, (a >= 16'h8000) ? 1 : 0);
      check_eq("rd_we", req_we, 0);
      check_eq("rd_data", bus_d_out, rd_next);
    end else begin
      check_eq("rd_noreq", req_cnt, cnt0);
      check_eq("rd_ff", bus_d_out, 8'hFF);
    end
    bus_rd_n = 1'b1;
    repeat (SYNC + 3) @(negedge clk);
    check_eq("rd_release", bus_d_oe, 0);
    bus_cs_n = 1'b1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input logic cs_n, input bit with_rd);
    int unsigned cnt0, ea;
    bit ramwr, oe_seen;
    cnt0    = req_cnt;
    ea      = exp_addr(a);
    ramwr   = ram_window(a, cs_n) && m_ram_en != 0;
    oe_seen = 0;
    @(negedge clk);
    bus_a    = a;
    bus_d_in = d;
    bus_cs_n = cs_n;
    bus_wr_n = 1'b0;
    if (with_rd) bus_rd_n = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus_d_oe) oe_seen = 1;
    end
    bus_wr_n = 1'b1;
    bus_rd_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus_d_oe) oe_seen = 1;
    end
    bus_cs_n = 1'b1;
    check_eq("wr_no_oe", oe_seen, 0);
    if (ramwr) begin
      check_eq("wr_req_cnt", req_cnt, cnt0 + 1);
      check_eq("wr_addr", req_addr, ea);
      check_eq("wr_sel", req_sel, 1);
      check_eq("wr_we", req_we, 1);
      check_eq("wr_data", req_wdata, d);
    end else begin
      check_eq("wr_noreq", req_cnt, cnt0);
    end
    model_write(a, d);
  endtask

  initial begin
    int unsigned cnt0;
    bit oe_seen;
    logic [15:0] ra;
    logic [7:0]  rdv;

    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_req", mem_req, 0);
    check_eq("rst_we", mem_we, 0);
    check_eq("rst_oe", bus_d_oe, 0);
    check_eq("rst_dout", bus_d_out, 8'hFF);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic ROM read with zero-cycle ack: latency is SYNC + 2
    force_delay = 0;
    do_read(16'h0100, 1'b1);
    check_eq("lat_d0", last_lat, SYNC + 2);
    force_delay = 2;
    do_read(16'h0200, 1'b1);
    check_eq("lat_d2", last_lat, SYNC + 4);
    force_delay = -1;

    // RAM gating
    do_read(16'hA000, 1'b0);
    do_write(16'hA010, 8'h12, 1'b0, 0);
    do_write(16'h0000, 8'h0A, 1'b1, 0);
    do_write(16'hB123, 8'h55, 1'b0, 0);
    do_read(16'hB123, 1'b0);
    do_read(16'hA000, 1'b1);

    // Bank1 zero maps to 1, then bank 31
    do_write(16'h2000, 8'h00, 1'b1, 0);
    do_read(16'h4000, 1'b1);
    do_write(16'h2000, 8'h1F, 1'b1, 0);
    do_read(16'h4000, 1'b1);
    do_write(16'h3FFF, 8'h20, 1'b1, 0);
    do_read(16'h5555, 1'b1);

    // Mode 1 with bank2 = 3
    do_write(16'h4000, 8'h03, 1'b1, 0);
    do_write(16'h6000, 8'h01, 1'b1, 0);
    do_write(16'h2000, 8'h05, 1'b1, 0);
    do_read(16'h0000, 1'b1);
    do_read(16'h7FFF, 1'b1);
    do_read(16'hBFFF, 1'b0);

    // Simultaneous rd/wr falls: write only
    do_write(16'h2000, 8'h03, 1'b1, 1);
    do_read(16'h4000, 1'b1);

    // Read aborted during FETCH
    force_delay = 8;
    cnt0 = ack_cnt;
    @(negedge clk);
    bus_a = 16'h1234;
    bus_rd_n = 1'b0;
    for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
    @(negedge clk);
    bus_rd_n = 1'b1;
    oe_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_d_oe) oe_seen = 1;
    end
    check_eq("abort_oe", oe_seen, 0);
    check_eq("abort_ack", ack_cnt, cnt0 + 1);
    check_eq("abort_idle_req", mem_req, 0);
    force_delay = -1;
    do_read(16'h1234, 1'b1);

    // Reset during FETCH, then a stray late ack
    hold_ack = 1;
    @(negedge clk);
    bus_a = 16'h4100;
    bus_rd_n = 1'b0;
    for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
    check_eq("fetch_req", mem_req, 1);
    rst = 1'b1;
    #1;
    check_eq("rst_req_drop", mem_req, 0);
    check_eq("rst_mid_oe", bus_d_oe, 0);
    @(negedge clk);
    bus_rd_n = 1'b1;
    hold_ack = 0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    late_ack = 1;
    oe_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus_d_oe) oe_seen = 1;
    end
    check_eq("late_ack_oe", oe_seen, 0);
    do_read(16'h4000, 1'b1);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          ra  = 16'($urandom_range(0, 16'h7FFF));
          rdv = 8'($urandom);
          if (ra < 16'h2000 && $urandom_range(0, 1) == 1) rdv = 8'h0A;
          do_write(ra, rdv, 1'b1, 0);
        end
        1: do_read(16'($urandom_range(0, 16'h7FFF)), 1'b1);
        2: do_read(16'($urandom_range(16'h8000, 16'hFFFF)), 1'($urandom_range(0, 1)));
        default: do_write(16'($urandom_range(16'h8000, 16'hFFFF)), 8'($urandom),
                          1'($urandom_range(0, 1)), 0);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
